// File: rtl/reaction_datapath_pkg.sv
// Shared definitions for the reaction timer: control-word bit positions,
// the packed view of the control word, the control FSM state encoding and
// the control word each FSM state drives. The control FSM and the datapath
// both import this package so the bit map lives in exactly one place.
package reaction_datapath_pkg;

    localparam int CTL_W          = 7;
    localparam int CTL_CLR_RT     = 0;
    localparam int CTL_RT_EN      = 1;
    localparam int CTL_LED_OFF    = 2;
    localparam int CTL_LOAD_DELAY = 3;
    localparam int CTL_DELAY_EN   = 4;
    localparam int CTL_LED_ON     = 5;
    localparam int CTL_STORE      = 6;

    // Field order is MSB first so a cast of the raw word lines up with the
    // bit indices above.
    typedef struct packed {
        logic store;
        logic led_on;
        logic delay_en;
        logic load_delay;
        logic led_off;
        logic rt_en;
        logic clr_rt;
    } ctl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_EARLY,
        ST_REACT,
        ST_STORE
    } fsm_state_t;

    // Control words driven by the Moore FSM in each state.
    localparam logic [CTL_W-1:0] CW_IDLE  = 7'b0000100; // LED off, everything idle
    localparam logic [CTL_W-1:0] CW_ARM   = 7'b0001101; // clear rt, LED off, load delay
    localparam logic [CTL_W-1:0] CW_WAIT  = 7'b0010000; // count the start delay down
    localparam logic [CTL_W-1:0] CW_EARLY = 7'b0000000; // early press: freeze everything
    localparam logic [CTL_W-1:0] CW_REACT = 7'b0100010; // LED on, count reaction time
    localparam logic [CTL_W-1:0] CW_STORE = 7'b1000000; // latch result / best score

    function automatic logic [CTL_W-1:0] fsm_controls(input fsm_state_t s);
        case (s)
            ST_IDLE:  return CW_IDLE;
            ST_ARM:   return CW_ARM;
            ST_WAIT:  return CW_WAIT;
            ST_EARLY: return CW_EARLY;
            ST_REACT: return CW_REACT;
            ST_STORE: return CW_STORE;
            default:  return CW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/reaction_datapath_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping every clock cycle.
// Seeded with 16'hACE1 on reset, so the all-zero lock-up state is never
// reached.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   q      out  current LFSR state
module lfsr16 (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 16'hACE1;
        end else begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/reaction_datapath.sv
// Datapath/timer half of the reaction timer. Decodes the 7-bit control word
// from the control FSM, produces the pseudo-random start delay and returns
// timer_trigger, counts the reaction time in ms, latches the last result,
// tracks the best score and drives the LED and the display value.
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   module_controls  in   FSM control word (see reaction_datapath_pkg)
//   show_best        in   1: display best score, 0: display last result
//   timer_trigger    out  high once the armed start delay has expired
//   led              out  stimulus LED
//   disp_ms          out  display value in binary ms
//   best_valid       out  at least one result stored since reset
//   new_best         out  last store improved the best score
module reaction_datapath
    import reaction_datapath_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 12,
    parameter int RT_MAX       = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  module_controls,
    input  logic        show_best,
    output logic        timer_trigger,
    output logic        led,
    output logic [13:0] disp_ms,
    output logic        best_valid,
    output logic        new_best
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [12:0]      MIN_DELAY = 13'(MIN_DELAY_MS);
    localparam logic [13:0]      RT_LIMIT  = 14'(RT_MAX);

    ctl_t             ctl;
    logic [15:0]      lfsr_q;
    logic [PRE_W-1:0] prescaler;
    logic             count_en;
    logic             tick;
    logic [12:0]      delay_cnt;
    logic [12:0]      delay_load;
    logic             armed;
    logic [13:0]      rt;
    logic [13:0]      result;
    logic [13:0]      best;
    logic             store_prev;
    logic             store_pulse;

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= RT_LIMIT) ? RT_LIMIT : v + 14'd1;
    endfunction

    assign ctl = ctl_t'(module_controls);

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr_q)
    );

    generate
        if (RAND_BITS < 16) begin : g_lfsr_spare
            logic unused_lfsr_bits;
            assign unused_lfsr_bits = ^lfsr_q[15:RAND_BITS];
        end
    endgenerate

    assign delay_load = MIN_DELAY + 13'(lfsr_q[RAND_BITS-1:0]);

    // The ms prescaler only runs while one of the timers is enabled, so an
    // early-stop freeze (delay_en dropped) postpones the countdown by exactly
    // the number of frozen cycles instead of losing partial ticks.
    assign count_en = ctl.delay_en | ctl.rt_en;
    assign tick     = count_en && (prescaler == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (ctl.load_delay) begin
            prescaler <= '0;
        end else if (count_en) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    // Start delay: trigger is registered off the current count, so it rises
    // one cycle after the tick that brings the counter to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay_cnt     <= '0;
            armed         <= 1'b0;
            timer_trigger <= 1'b0;
        end else if (ctl.load_delay) begin
            delay_cnt     <= delay_load;
            armed         <= 1'b1;
            timer_trigger <= 1'b0;
        end else begin
            if (ctl.delay_en && tick && (delay_cnt != 13'd0)) begin
                delay_cnt <= delay_cnt - 13'd1;
            end
            if (armed && (delay_cnt == 13'd0)) begin
                timer_trigger <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rt <= '0;
        end else if (ctl.clr_rt) begin
            rt <= '0;
        end else if (ctl.rt_en && tick) begin
            rt <= sat_inc(rt);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led <= 1'b0;
        end else if (ctl.led_off) begin
            led <= 1'b0;
        end else if (ctl.led_on) begin
            led <= 1'b1;
        end
    end

    // Only the first cycle of a held store updates the scores.
    assign store_pulse = ctl.store & ~store_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            store_prev <= 1'b0;
            result     <= '0;
            best       <= '0;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
        end else begin
            store_prev <= ctl.store;
            if (store_pulse) begin
                result <= rt;
                if (!best_valid || (rt < best)) begin
                    best       <= rt;
                    best_valid <= 1'b1;
                    new_best   <= 1'b1;
                end else begin
                    new_best   <= 1'b0;
                end
            end
        end
    end

    assign disp_ms = show_best ? best : result;

endmodule

// File: tb/tb_reaction_datapath.sv
module tb_reaction_datapath;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LOFF  = 7'b0000100;
    localparam logic [6:0] C_ARM   = 7'b0001101;
    localparam logic [6:0] C_WAIT  = 7'b0010000;
    localparam logic [6:0] C_REACT = 7'b0100010;
    localparam logic [6:0] C_BOTH  = 7'b0100110;
    localparam logic [6:0] C_RTEN  = 7'b0000010;
    localparam logic [6:0] C_STORE = 7'b1000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  ctl   = 7'b0;
    logic        show_best = 1'b0;
    logic        timer_trigger, led, best_valid, new_best;
    logic [13:0] disp_ms;

    logic [6:0]  ctl2 = 7'b0;
    logic        show_best2 = 1'b0;
    logic        trig2, led2, bv2, nb2;
    logic [13:0] disp2;

    logic [15:0] m;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) m <= 16'hACE1;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    reaction_datapath #(.CLK_HZ(10_000), .MIN_DELAY_MS(2), .RAND_BITS(2), .RT_MAX(9999)) dut (
        .clock(clock), .reset(reset), .module_controls(ctl), .show_best(show_best),
        .timer_trigger(timer_trigger), .led(led), .disp_ms(disp_ms),
        .best_valid(best_valid), .new_best(new_best)
    );

    reaction_datapath #(.CLK_HZ(2_000), .MIN_DELAY_MS(2), .RAND_BITS(2), .RT_MAX(9999)) dut_sat (
        .clock(clock), .reset(reset), .module_controls(ctl2), .show_best(show_best2),
        .timer_trigger(trig2), .led(led2), .disp_ms(disp2),
        .best_valid(bv2), .new_best(nb2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to_trigger(output int lat, output int n_exp);
        ctl   = C_ARM;
        n_exp = 2 + int'(m[1:0]);
        step();
        ctl = C_WAIT;
        lat = -1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (timer_trigger) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_run(input int react_cycles, output int lat, output int n_exp);
        run_to_trigger(lat, n_exp);
        ctl = C_REACT;
        repeat (react_cycles) step();
        ctl = C_STORE;
        repeat (2) step();
        ctl = C_NONE;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; ctl = C_NONE; show_best = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (timer_trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %0b expected 0", timer_trigger); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %0b expected 0", led); end
        checks++; if (disp_ms !== 14'd0) begin errors++; $display("FAIL reset_disp: got %0d expected 0", disp_ms); end
        checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL reset_best_valid: got %0b expected 0", best_valid); end
        checks++; if (dut.u_lfsr.q !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.q); end
        #1 reset = 1'b0;
        step();
    endtask

    task automatic test_delay();
        int lat, n;
        checks++; if (dut.u_lfsr.q !== m) begin errors++; $display("FAIL lfsr_sequence: got %h expected %h", dut.u_lfsr.q, m); end
        run_to_trigger(lat, n);
        checks++; if (lat !== 10 * n + 1) begin errors++; $display("FAIL delay_latency: got %0d expected %0d", lat, 10 * n + 1); end
        repeat (5) step();
        checks++; if (timer_trigger !== 1'b1) begin errors++; $display("FAIL trigger_hold: got %0b expected 1", timer_trigger); end
        ctl = C_NONE;
        step();
    endtask

    task automatic test_freeze();
        int n, lat;
        ctl = C_ARM;
        n   = 2 + int'(m[1:0]);
        step();
        ctl = C_WAIT;
        repeat (15) step();
        ctl = C_NONE;
        repeat (35) step();
        checks++; if (dut.delay_cnt !== 13'(n - 1)) begin errors++; $display("FAIL freeze_count: got %0d expected %0d", dut.delay_cnt, n - 1); end
        checks++; if (timer_trigger !== 1'b0) begin errors++; $display("FAIL freeze_trigger: got %0b expected 0", timer_trigger); end
        ctl = C_WAIT;
        lat = -1;
        for (int i = 51; i <= 1000; i++) begin
            step();
            if (timer_trigger) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat !== 10 * n + 1 + 35) begin errors++; $display("FAIL freeze_latency: got %0d expected %0d", lat, 10 * n + 36); end
        ctl = C_NONE;
        step();
    endtask

    task automatic test_store_runs();
        int lat, n;
        // Run 1: 123 react cycles -> 12 ms, first result becomes best.
        do_run(123, lat, n);
        show_best = 1'b0; #1;
        checks++; if (disp_ms !== 14'd12) begin errors++; $display("FAIL run1_result: got %0d expected 12", disp_ms); end
        show_best = 1'b1; #1;
        checks++; if (disp_ms !== 14'd12) begin errors++; $display("FAIL run1_best: got %0d expected 12", disp_ms); end
        checks++; if (best_valid !== 1'b1 || new_best !== 1'b1) begin errors++; $display("FAIL run1_flags: got valid=%0b new=%0b expected 1 1", best_valid, new_best); end
        // Run 2: 20 ms, slower -> best kept.
        do_run(203, lat, n);
        checks++; if (lat !== 10 * n + 1) begin errors++; $display("FAIL run2_latency: got %0d expected %0d", lat, 10 * n + 1); end
        show_best = 1'b0; #1;
        checks++; if (disp_ms !== 14'd20) begin errors++; $display("FAIL run2_result: got %0d expected 20", disp_ms); end
        show_best = 1'b1; #1;
        checks++; if (disp_ms !== 14'd12) begin errors++; $display("FAIL run2_best: got %0d expected 12", disp_ms); end
        checks++; if (new_best !== 1'b0) begin errors++; $display("FAIL run2_new_best: got %0b expected 0", new_best); end
        // Run 3: 7 ms -> new best.
        do_run(73, lat, n);
        show_best = 1'b0; #1;
        checks++; if (disp_ms !== 14'd7) begin errors++; $display("FAIL run3_result: got %0d expected 7", disp_ms); end
        show_best = 1'b1; #1;
        checks++; if (disp_ms !== 14'd7) begin errors++; $display("FAIL run3_best: got %0d expected 7", disp_ms); end
        checks++; if (new_best !== 1'b1) begin errors++; $display("FAIL run3_new_best: got %0b expected 1", new_best); end
        // Run 4: equal to best -> not a new best.
        do_run(73, lat, n);
        checks++; if (new_best !== 1'b0 || disp_ms !== 14'd7) begin errors++; $display("FAIL run4_tie: got new=%0b best=%0d expected 0 7", new_best, disp_ms); end
        show_best = 1'b0;
    endtask

    task automatic test_led();
        int lat, n;
        run_to_trigger(lat, n);
        ctl = C_REACT;
        step();
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL led_on: got %0b expected 1", led); end
        ctl = C_BOTH;
        step();
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL led_off_wins: got %0b expected 0", led); end
        ctl = C_REACT;
        step();
        ctl = C_NONE;
        step();
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL led_hold: got %0b expected 1", led); end
        ctl = C_LOFF;
        step();
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL led_idle_off: got %0b expected 0", led); end
    endtask

    task automatic test_reset_midop();
        int lat, n;
        run_to_trigger(lat, n);
        ctl = C_REACT;
        repeat (30) step();
        show_best = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (timer_trigger !== 1'b0 || led !== 1'b0) begin errors++; $display("FAIL async_reset_outputs: got trig=%0b led=%0b expected 0 0", timer_trigger, led); end
        checks++; if (best_valid !== 1'b0 || disp_ms !== 14'd0) begin errors++; $display("FAIL async_reset_best: got valid=%0b best=%0d expected 0 0", best_valid, disp_ms); end
        @(posedge clock); #1 reset = 1'b0;
        ctl = C_NONE; show_best = 1'b0;
        step();
        // Reset during the countdown disarms the delay.
        ctl = C_ARM;
        step();
        ctl = C_WAIT;
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        checks++; if (dut.u_lfsr.q !== 16'hACE1) begin errors++; $display("FAIL countdown_reset_lfsr: got %h expected ace1", dut.u_lfsr.q); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (100) step();
        checks++; if (timer_trigger !== 1'b0) begin errors++; $display("FAIL disarmed_trigger: got %0b expected 0", timer_trigger); end
        ctl = C_NONE;
        step();
    endtask

    task automatic test_saturation();
        ctl2 = C_RTEN;
        repeat (200) step();
        ctl2 = C_STORE;
        repeat (2) step();
        ctl2 = C_NONE;
        step();
        show_best2 = 1'b0; #1;
        checks++; if (disp2 !== 14'd100) begin errors++; $display("FAIL sat_pre_result: got %0d expected 100", disp2); end
        ctl2 = C_RTEN;
        repeat (20000) step();
        ctl2 = C_STORE;
        repeat (2) step();
        ctl2 = C_NONE;
        step();
        checks++; if (disp2 !== 14'd9999) begin errors++; $display("FAIL sat_result: got %0d expected 9999", disp2); end
        show_best2 = 1'b1; #1;
        checks++; if (disp2 !== 14'd100 || nb2 !== 1'b0) begin errors++; $display("FAIL sat_best: got best=%0d new=%0b expected 100 0", disp2, nb2); end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_freeze();
        test_store_runs();
        test_led();
        test_reset_midop();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
